// File: rtl/sau_pkg.sv
// Shared types and index helpers for the SAU sequencer.
package sau_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sau_state_t;

  function automatic int feed_beats(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int elem_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/sau_skew_feeder.sv
// Combinational skew generator: for beat t, row lane i carries A[i][t-i] and
// column lane j carries B[t-j][j]; lanes outside their window are zero.
module sau_skew_feeder
  import sau_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32,
  parameter int CNT_W       = 2
) (
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] a_mat,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] b_mat,
  input  logic [CNT_W-1:0]                             beat,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]             row_in,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]             col_in
);

  always_comb begin
    row_in = '0;
    col_in = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      if (int'(beat) >= i && int'(beat) - i < MATRIX_SIZE) begin
        row_in[i*DATA_SIZE +: DATA_SIZE] =
          a_mat[elem_idx(i, int'(beat) - i, MATRIX_SIZE)*DATA_SIZE +: DATA_SIZE];
        col_in[i*DATA_SIZE +: DATA_SIZE] =
          b_mat[elem_idx(int'(beat) - i, i, MATRIX_SIZE)*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

endmodule

// File: rtl/sau_sequencer.sv
// Sequences one output-stationary systolic array: clear, skewed feed, drain, capture, respond.
// Define SAU_PERF_EN to add perf_busy_cycles / perf_ops counters.
module sau_sequencer
  import sau_pkg::*;
#(
  parameter int MATRIX_SIZE  = 2,
  parameter int DATA_SIZE    = 32,
  parameter int TAG_WIDTH    = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] req_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] req_b,
  input  logic [TAG_WIDTH-1:0]                         req_tag,
  output logic                                         sa_clear,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]             sa_in_a,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0]             sa_in_b,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] sa_out,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]                         rsp_tag
`ifdef SAU_PERF_EN
  ,
  output logic [31:0]                                  perf_busy_cycles,
  output logic [31:0]                                  perf_ops
`endif
);

  localparam int MAT_W   = MATRIX_SIZE * MATRIX_SIZE * DATA_SIZE;
  localparam int FEED_N  = feed_beats(MATRIX_SIZE);
  localparam int CNT_MAX = max_int(FEED_N, DRAIN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  sau_state_t state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 accept, capture;
  logic [MAT_W-1:0]     a_lat, b_lat;
  logic [TAG_WIDTH-1:0] tag_lat;
  logic [MATRIX_SIZE*DATA_SIZE-1:0] feed_a, feed_b;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = FEED;
        cnt_next   = '0;
      end
      FEED: begin
        if (cnt == CNT_W'(FEED_N - 1)) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_next = DONE;
          capture    = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Feeder looks at the upcoming beat so the array edge registers carry beat t during FEED cycle t.
  sau_skew_feeder #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .DATA_SIZE   (DATA_SIZE),
    .CNT_W       (CNT_W)
  ) u_feeder (
    .a_mat  (a_lat),
    .b_mat  (b_lat),
    .beat   (cnt_next),
    .row_in (feed_a),
    .col_in (feed_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_lat    <= '0;
      b_lat    <= '0;
      tag_lat  <= '0;
      sa_clear <= 1'b0;
      sa_in_a  <= '0;
      sa_in_b  <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      sa_clear <= (state_next == CLEAR);
      sa_in_a  <= (state_next == FEED) ? feed_a : '0;
      sa_in_b  <= (state_next == FEED) ? feed_b : '0;
      if (accept) begin
        a_lat   <= req_a;
        b_lat   <= req_b;
        tag_lat <= req_tag;
      end
      if (capture) begin
        rsp_data <= sa_out;
        rsp_tag  <= tag_lat;
      end
    end
  end

`ifdef SAU_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles <= '0;
      perf_ops         <= '0;
    end else begin
      if (state != IDLE) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (state == DONE && rsp_ready) perf_ops <= perf_ops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sau_sequencer.sv
// Bench for sau_sequencer: behavioural output-stationary array, vector table, scoreboard.
module tb_sau_sequencer;

  localparam int N  = 2;
  localparam int DS = 32;
  localparam int TW = 8;
  localparam int DC = 3;
  localparam int W  = N * N * DS;
  localparam int NV = 5;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, rsp_valid, rsp_ready, sa_clear;
  logic [W-1:0]    req_a, req_b, sa_out, rsp_data;
  logic [TW-1:0]   req_tag, rsp_tag;
  logic [N*DS-1:0] sa_in_a, sa_in_b;
`ifdef SAU_PERF_EN
  logic [31:0] perf_busy_cycles, perf_ops;
`endif

  always #5 clk = ~clk;

  sau_sequencer #(.MATRIX_SIZE(N), .DATA_SIZE(DS), .TAG_WIDTH(TW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .sa_clear(sa_clear),
    .sa_in_a(sa_in_a), .sa_in_b(sa_in_b), .sa_out(sa_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag)
`ifdef SAU_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_ops(perf_ops)
`endif
  );

  // Output-stationary array: A flows right, B flows down, each PE accumulates a*b.
  logic [DS-1:0] pa [N][N];
  logic [DS-1:0] pb [N][N];
  logic [DS-1:0] acc [N][N];
  logic [DS-1:0] ea [N][N+1];
  logic [DS-1:0] eb [N+1][N];

  always_comb begin
    ea = '{default: '0};
    eb = '{default: '0};
    for (int i = 0; i < N; i++) begin
      ea[i][0] = sa_in_a[i*DS +: DS];
      eb[0][i] = sa_in_b[i*DS +: DS];
      for (int j = 0; j < N; j++) begin
        ea[i][j+1] = pa[i][j];
        eb[i+1][j] = pb[i][j];
      end
    end
  end

  always_comb begin
    sa_out = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sa_out[(i*N+j)*DS +: DS] = acc[i][j];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pa[i][j]  <= ea[i][j];
        pb[i][j]  <= eb[i][j];
        acc[i][j] <= sa_clear ? '0 : acc[i][j] + ea[i][j] * eb[i][j];
      end
  end

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
  } vec_t;

  typedef struct {
    logic [W-1:0]  c;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic          clr;
    logic [N*DS-1:0] a;
    logic [N*DS-1:0] b;
  } skew_t;

  vec_t  vecs [NV];
  skew_t skew [5];
  exp_t  sb [$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] mk(input logic [DS-1:0] e00, input logic [DS-1:0] e01,
                                      input logic [DS-1:0] e10, input logic [DS-1:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic logic [W-1:0] matmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]  c;
    logic [DS-1:0] s;
    c = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++)
          s = s + a[(i*N+k)*DS +: DS] * b[(k*N+j)*DS +: DS];
        c[(i*N+j)*DS +: DS] = s;
      end
    return c;
  endfunction

  // Scoreboard consumer: compare at the cycle in which the response handshake occurs.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got tag=%h want=no response", rsp_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.c);
        chk("rsp_tag", W'(rsp_tag), W'(e.tag));
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    @(negedge clk);
    req_a = v.a; req_b = v.b; req_tag = v.tag; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", W'(req_ready), W'(1));
    if (req_ready) sb.push_back('{v.c, v.tag});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", W'(rsp_valid), W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
`ifdef SAU_PERF_EN
    logic [31:0] busy0, ops0;
`endif
    vecs[0] = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8), mk(19, 22, 43, 50), 8'h3C};
    vecs[1] = '{mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), mk(1, 0, 0, 1),
                mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 8'hA5};
    vecs[2] = '{mk(2, 0, 0, 2), mk(9, 8, 7, 6), mk(18, 16, 14, 12), 8'h01};
    vecs[3] = '{mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), mk(2, 2, 2, 2),
                mk(32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC), 8'h7E};
    for (int e = 0; e < N * N; e++) begin
      vecs[4].a[e*DS +: DS] = $urandom();
      vecs[4].b[e*DS +: DS] = $urandom();
    end
    vecs[4].c   = matmul(vecs[4].a, vecs[4].b);
    vecs[4].tag = 8'hC3;

    skew[0] = '{1'b1, {32'd0, 32'd0}, {32'd0, 32'd0}};
    skew[1] = '{1'b0, {32'd0, 32'd1}, {32'd0, 32'd5}};
    skew[2] = '{1'b0, {32'd3, 32'd2}, {32'd6, 32'd7}};
    skew[3] = '{1'b0, {32'd4, 32'd0}, {32'd8, 32'd0}};
    skew[4] = '{1'b0, {32'd0, 32'd0}, {32'd0, 32'd0}};

    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_sa_clear", W'(sa_clear), W'(0));
    chk("rst_sa_in_a", W'(sa_in_a), W'(0));
    chk("rst_sa_in_b", W'(sa_in_b), W'(0));
    chk("rst_rsp_data", rsp_data, W'(0));
    chk("rst_rsp_tag", W'(rsp_tag), W'(0));
`ifdef SAU_PERF_EN
    chk("rst_perf_busy", W'(perf_busy_cycles), W'(0));
    chk("rst_perf_ops", W'(perf_ops), W'(0));
`endif

    // Skew pattern and exact latency on the basic operands.
    send(vecs[0]);
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("skew_clr_%0d", s), W'(sa_clear), W'(skew[s].clr));
      chk($sformatf("skew_a_%0d", s), W'(sa_in_a), W'(skew[s].a));
      chk($sformatf("skew_b_%0d", s), W'(sa_in_b), W'(skew[s].b));
    end
    n = 5;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", W'(n), W'(2 * N + DC + 1));
    @(posedge clk);
    #1;

    // Table of operand pairs through the scoreboard.
    for (int k = 0; k < NV; k++) begin
`ifdef SAU_PERF_EN
      busy0 = perf_busy_cycles;
      ops0  = perf_ops;
`endif
      send(vecs[k]);
      wait_rsp();
      @(posedge clk);
      #1;
`ifdef SAU_PERF_EN
      chk($sformatf("perf_busy_%0d", k), W'(perf_busy_cycles - busy0), W'(2 * N + DC + 1));
      chk($sformatf("perf_ops_%0d", k), W'(perf_ops - ops0), W'(1));
`endif
    end

    // Backpressure with a second request pending, then back-to-back accept.
    rsp_ready = 1'b0;
    send(vecs[2]);
    wait_rsp();
    req_a = vecs[3].a; req_b = vecs[3].b; req_tag = vecs[3].tag; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", W'(rsp_valid), W'(1));
      chk("bp_rsp_data", rsp_data, vecs[2].c);
      chk("bp_rsp_tag", W'(rsp_tag), W'(vecs[2].tag));
      chk("bp_req_ready", W'(req_ready), W'(0));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_no_bypass_valid", W'(rsp_valid), W'(0));
    chk("b2b_idle_ready", W'(req_ready), W'(1));
    sb.push_back('{vecs[3].c, vecs[3].tag});
    @(posedge clk);
    #1;
    chk("b2b_accepted", W'(req_ready), W'(0));
    req_valid = 1'b0;
    wait_rsp();
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of FEED discards the operation.
    send(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_feed_a", W'(sa_in_a), W'({32'd3, 32'd2}));
    #2 reset = 1'b0;
    #1;
    chk("arst_sa_in_a", W'(sa_in_a), W'(0));
    chk("arst_sa_in_b", W'(sa_in_b), W'(0));
    chk("arst_sa_clear", W'(sa_clear), W'(0));
    chk("arst_rsp_valid", W'(rsp_valid), W'(0));
    chk("arst_req_ready", W'(req_ready), W'(1));
    sb.delete();
    @(negedge clk) reset = 1'b1;
    #1;
    chk("arst_release_ready", W'(req_ready), W'(1));
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("arst_no_rsp", W'(n), W'(0));

    // Fresh operation after reset still produces a clean result.
    send(vecs[2]);
    wait_rsp();
    @(posedge clk);
    #1;
    chk("sb_drained", W'(sb.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
